// File: rtl/clock_pkg.sv
// Shared types and helpers for the HH:MM clock set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_t;

  localparam logic [3:0] BLANK_HOUR = 4'b1100;
  localparam logic [3:0] BLANK_MIN  = 4'b0011;

  // Clock cycles per millisecond.
  function automatic int MS_DIV(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  // Digits belonging to the field being edited in a given mode.
  function automatic logic [3:0] field_mask(input mode_t m);
    case (m)
      SET_HOUR: return BLANK_HOUR;
      SET_MIN:  return BLANK_MIN;
      default:  return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button inputs and datapath/display controls of the clock set controller.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       clk_enable;
  logic       hour_inc;
  logic       hour_dec;
  logic       min_inc;
  logic       min_dec;
  logic [3:0] blank;
  logic [1:0] mode_state;

  // Button/debouncer side drives the buttons and observes the controls.
  modport master (
    output btn_mode, btn_up, btn_down,
    input  clk_enable, hour_inc, hour_dec, min_inc, min_dec, blank, mode_state
  );

  // Controller side.
  modport slave (
    input  btn_mode, btn_up, btn_down,
    output clk_enable, hour_inc, hour_dec, min_inc, min_dec, blank, mode_state
  );
endinterface

// File: rtl/ms_tick_gen.sv
// Prescaler: one-cycle tick every DIV clocks (constant high when DIV == 1).
module ms_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  // Count 0..DIV-1 and wrap on the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set mode controller for the HH:MM clock: buttons -> enable, adjust
// pulses and blink mask. Optional auto-repeat: CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int HOLD_MS    = 500,
  parameter int REPEAT_MS  = 100,
  parameter int BLINK_MS   = 250,
  parameter int TIMEOUT_MS = 10000
) (
  input  logic             clk,
  input  logic             rst_n,
  clock_set_ctrl_if.slave  bus
);
  localparam int IW = $clog2(TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);

  logic          tick_ms;
  mode_t         state, state_n;
  logic          prev_mode, prev_up, prev_down;
  logic          rise_mode, rise_up, rise_down;
  logic          both, any_high, in_set, timeout, adj_ok, up_ev, dn_ev;
  logic          inhibit, inhibit_n;
  logic [IW-1:0] idle, idle_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          phase, phase_n;
  logic          fire, fire_dn, inc, dec;
  logic          clk_en_q, hour_inc_q, hour_dec_q, min_inc_q, min_dec_q;
  logic [3:0]    blank_q;

  ms_tick_gen #(.DIV(MS_DIV(CLK_HZ))) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick_ms)
  );

  assign rise_mode = bus.btn_mode & ~prev_mode;
  assign rise_up   = bus.btn_up   & ~prev_up;
  assign rise_down = bus.btn_down & ~prev_down;
  assign both      = bus.btn_up & bus.btn_down;
  assign any_high  = bus.btn_mode | bus.btn_up | bus.btn_down;
  assign in_set    = (state == SET_HOUR) || (state == SET_MIN);
  assign timeout   = in_set && (idle == IW'(TIMEOUT_MS));

  // Next mode, idle timer, up/down inhibit and single-press adjust events.
  always_comb begin
    state_n = state;
    case (state)
      RUN:      if (rise_mode) state_n = SET_HOUR;
      SET_HOUR: if (timeout) state_n = RUN; else if (rise_mode) state_n = SET_MIN;
      SET_MIN:  if (timeout || rise_mode) state_n = RUN;
      default:  state_n = RUN;
    endcase

    idle_n = idle;
    if (any_high)                                   idle_n = '0;
    else if (tick_ms && idle != IW'(TIMEOUT_MS))    idle_n = idle + IW'(1);

    // Both adjust buttons down locks out adjusting until both are released.
    inhibit_n = inhibit;
    if (both)                                 inhibit_n = 1'b1;
    else if (!bus.btn_up && !bus.btn_down)    inhibit_n = 1'b0;

    // Mode transitions (and timeouts) swallow a coincident adjust.
    adj_ok = in_set && (state_n == state) && !both && !inhibit;
    up_ev  = rise_up   & adj_ok;
    dn_ev  = rise_down & adj_ok;
  end

  // Blink phase restarts at 0 on every SET entry and only runs in SET.
  always_comb begin
    blink_cnt_n = blink_cnt;
    phase_n     = phase;
    if (state_n == RUN || state_n != state) begin
      blink_cnt_n = '0;
      phase_n     = 1'b0;
    end else if (tick_ms) begin
      if (blink_cnt == BW'(BLINK_MS - 1)) begin
        blink_cnt_n = '0;
        phase_n     = ~phase;
      end else begin
        blink_cnt_n = blink_cnt + BW'(1);
      end
    end
  end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int RMAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int RW   = $clog2(RMAX + 1);

  logic          rep_arm, rep_arm_n, rep_dir, rep_dir_n, rep_run, rep_run_n;
  logic [RW-1:0] rep_cnt, rep_cnt_n, rep_tgt;

  // Hold timer then repeat timer for the button that produced the last press;
  // any release, dual press or mode change disarms it until a fresh rise.
  always_comb begin
    rep_arm_n = rep_arm;
    rep_dir_n = rep_dir;
    rep_run_n = rep_run;
    rep_cnt_n = rep_cnt;
    fire      = 1'b0;
    rep_tgt   = rep_run ? RW'(REPEAT_MS) : RW'(HOLD_MS);
    if (up_ev || dn_ev) begin
      rep_arm_n = 1'b1;
      rep_dir_n = dn_ev;
      rep_run_n = 1'b0;
      rep_cnt_n = '0;
    end else if (!rep_arm || both || state_n != state ||
                 (rep_dir ? !bus.btn_down : !bus.btn_up)) begin
      rep_arm_n = 1'b0;
      rep_run_n = 1'b0;
      rep_cnt_n = '0;
    end else if (tick_ms) begin
      if (rep_cnt + RW'(1) == rep_tgt) begin
        fire      = 1'b1;
        rep_run_n = 1'b1;
        rep_cnt_n = '0;
      end else begin
        rep_cnt_n = rep_cnt + RW'(1);
      end
    end
  end

  // Auto-repeat state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_arm <= 1'b0;
      rep_dir <= 1'b0;
      rep_run <= 1'b0;
      rep_cnt <= '0;
    end else begin
      rep_arm <= rep_arm_n;
      rep_dir <= rep_dir_n;
      rep_run <= rep_run_n;
      rep_cnt <= rep_cnt_n;
    end
  end

  assign fire_dn = rep_dir;
`else
  assign fire    = 1'b0;
  assign fire_dn = 1'b0;
`endif

  assign inc = up_ev | (fire & ~fire_dn);
  assign dec = dn_ev | (fire &  fire_dn);

  // Mode FSM, timers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      prev_mode  <= 1'b0;
      prev_up    <= 1'b0;
      prev_down  <= 1'b0;
      inhibit    <= 1'b0;
      idle       <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      clk_en_q   <= 1'b1;
      hour_inc_q <= 1'b0;
      hour_dec_q <= 1'b0;
      min_inc_q  <= 1'b0;
      min_dec_q  <= 1'b0;
      blank_q    <= 4'b0000;
    end else begin
      state      <= state_n;
      prev_mode  <= bus.btn_mode;
      prev_up    <= bus.btn_up;
      prev_down  <= bus.btn_down;
      inhibit    <= inhibit_n;
      idle       <= idle_n;
      blink_cnt  <= blink_cnt_n;
      phase      <= phase_n;
      clk_en_q   <= (state_n == RUN);
      hour_inc_q <= inc & (state == SET_HOUR);
      hour_dec_q <= dec & (state == SET_HOUR);
      min_inc_q  <= inc & (state == SET_MIN);
      min_dec_q  <= dec & (state == SET_MIN);
      blank_q    <= (phase_n && !bus.btn_up && !bus.btn_down) ? field_mask(state_n) : 4'b0000;
    end
  end

  assign bus.clk_enable = clk_en_q;
  assign bus.hour_inc   = hour_inc_q;
  assign bus.hour_dec   = hour_dec_q;
  assign bus.min_inc    = min_inc_q;
  assign bus.min_dec    = min_dec_q;
  assign bus.blank      = blank_q;
  assign bus.mode_state = state;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl (ms tick every cycle).
module tb_clock_set_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .CLK_HZ    (1000),
    .HOLD_MS   (5),
    .REPEAT_MS (2),
    .BLINK_MS  (3),
    .TIMEOUT_MS(20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] pulses;
  assign pulses = {bus.hour_inc, bus.hour_dec, bus.min_inc, bus.min_dec};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle press of btn_mode; returns at the sample point after the edge.
  task automatic press_mode();
    bus.btn_mode = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    logic [15:0] want;
    logic [3:0]  acc;
    logic [8:0]  blink_exp;

    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_clk_enable", 16'(bus.clk_enable), 16'h1);
    check("reset_mode_state", 16'(bus.mode_state), 16'h0);
    check("reset_blank",      16'(bus.blank),      16'h0);
    check("reset_pulses",     16'(pulses),         16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode cycling
    press_mode();
    check("mode1_state", 16'(bus.mode_state), 16'h1);
    check("mode1_clken", 16'(bus.clk_enable), 16'h0);
    @(negedge clk);
    press_mode();
    check("mode2_state", 16'(bus.mode_state), 16'h2);
    check("mode2_clken", 16'(bus.clk_enable), 16'h0);
    @(negedge clk);
    press_mode();
    check("mode3_state", 16'(bus.mode_state), 16'h0);
    check("mode3_clken", 16'(bus.clk_enable), 16'h1);

    // Up/down ignored in RUN
    bus.btn_up = 1'b1;
    @(negedge clk);
    check("run_up_ignored", 16'(pulses), 16'h0);
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b1;
    @(negedge clk);
    check("run_down_ignored", 16'(pulses), 16'h0);
    bus.btn_down = 1'b0;
    @(negedge clk);
    check("run_blank", 16'(bus.blank), 16'h0);

    // Hour adjust: three presses, one pulse each
    press_mode();
    check("sethour_state", 16'(bus.mode_state), 16'h1);
    for (int i = 0; i < 3; i++) begin
      bus.btn_up = 1'b1;
      @(negedge clk);
      check($sformatf("hour_inc_%0d", i), 16'(pulses), 16'b1000);
      bus.btn_up = 1'b0;
      @(negedge clk);
      check($sformatf("hour_inc_end_%0d", i), 16'(pulses), 16'h0);
      @(negedge clk);
    end

    // Both adjust buttons together: nothing, even when held
    bus.btn_up = 1'b1;
    bus.btn_down = 1'b1;
    acc = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc = acc | pulses;
    end
    check("both_no_pulse", 16'(acc), 16'h0);
    check("both_no_blank", 16'(bus.blank), 16'h0);
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    @(negedge clk);

    // Mode and up together: mode wins, held up stays silent
    bus.btn_mode = 1'b1;
    bus.btn_up = 1'b1;
    @(negedge clk);
    check("mode_up_state", 16'(bus.mode_state), 16'h2);
    check("mode_up_pulses", 16'(pulses), 16'h0);
    bus.btn_mode = 1'b0;
    acc = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acc = acc | pulses;
    end
    check("held_after_mode", 16'(acc), 16'h0);
    bus.btn_up = 1'b0;
    @(negedge clk);

    // Hold down 12 cycles in SET_MIN; bit k = min_dec seen k cycles after rise
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    want = 16'b0001_0101_0100_0010;
`else
    want = 16'b0000_0000_0000_0010;
`endif
    got = 16'h0;
    acc = 4'h0;
    bus.btn_down = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      got[k] = bus.min_dec;
      acc = acc | {bus.hour_inc, bus.hour_dec, bus.min_inc, 1'b0};
      if (k == 12) bus.btn_down = 1'b0;
    end
    check("min_dec_pattern", got, want);
    check("min_hold_other", 16'(acc), 16'h0);

    // Blink: re-enter SET_MIN fresh, idle buttons
    @(negedge clk);
    press_mode();
    @(negedge clk);
    press_mode();
    @(negedge clk);
    press_mode();
    check("blink_state", 16'(bus.mode_state), 16'h2);
    blink_exp = 9'b000_111_000;
    for (int j = 0; j < 9; j++) begin
      check($sformatf("blink_%0d", j), 16'(bus.blank), blink_exp[j] ? 16'h3 : 16'h0);
      @(negedge clk);
    end

    // Timeout: SET_HOUR entered, idle -> RUN 21 cycles after the rise
    press_mode();
    check("timeout_pre_run", 16'(bus.mode_state), 16'h0);
    @(negedge clk);
    press_mode();
    for (int c = 0; c < 20; c++) @(negedge clk);
    check("timeout_c20_state", 16'(bus.mode_state), 16'h1);
    @(negedge clk);
    check("timeout_c21_state", 16'(bus.mode_state), 16'h0);
    check("timeout_c21_clken", 16'(bus.clk_enable), 16'h1);

    // Async reset in the middle of a held press
    @(negedge clk);
    press_mode();
    bus.btn_up = 1'b1;
    @(negedge clk);
    check("pre_reset_pulse", 16'(pulses), 16'b1000);
    check("pre_reset_state", 16'(bus.mode_state), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pulses", 16'(pulses), 16'h0);
    check("async_rst_state",  16'(bus.mode_state), 16'h0);
    check("async_rst_clken",  16'(bus.clk_enable), 16'h1);
    check("async_rst_blank",  16'(bus.blank), 16'h0);
    bus.btn_up = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_state", 16'(bus.mode_state), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Mode/adjust controller for the HH:MM clock datapath and its 4-digit multiplexed display.
- Turns three debounced push-buttons (mode, up, down) into a run/set FSM.
- Drives datapath enable, single-cycle hour/minute inc/dec pulses, and a per-digit blank mask for blinking the field being edited.
- Sits between the button debouncers and the clock/display datapath. Replaces raw button wiring to the datapath.

Parameters:
- CLK_HZ, 50000000: input clock frequency. Must be a multiple of 1000.
- HOLD_MS, 500: continuous hold time before auto-repeat starts.
- REPEAT_MS, 100: auto-repeat pulse period.
- BLINK_MS, 250: half-period of the edit-field blink.
- TIMEOUT_MS, 10000: inactivity time after which a set state returns to RUN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_mode  in  1  debounced level, synchronous to clk
- btn_up  in  1  debounced level, synchronous to clk
- btn_down  in  1  debounced level, synchronous to clk
- clk_enable  out  1  1 = datapath counts time; 0 = paused for editing
- hour_inc  out  1  one-cycle pulse
- hour_dec  out  1  one-cycle pulse
- min_inc  out  1  one-cycle pulse
- min_dec  out  1  one-cycle pulse
- blank  out  4  per-digit blank: [3:2] hour tens/units, [1:0] minute tens/units
- mode_state  out  2  current FSM state encoding

Behaviour:
- Reset (async assert, sync release):
  - state=RUN, clk_enable=1, all pulses 0, blank=4'b0000, mode_state=2'b00.
  - All counters and previous-button registers cleared.
- ms tick: prescaler counts 0..CLK_HZ/1000-1 and emits a one-cycle tick_ms. All ms counters advance only on tick_ms.
- Edge detection: rise_x = btn_x & ~prev_x, with prev_x registered every cycle.
- Output latency: every output is registered, so a pulse goes high exactly 1 cycle after the cycle in which the rise is sampled.
- FSM states: RUN=00, SET_HOUR=01, SET_MIN=10. Encoding 11 is unused and recovers to RUN on the next cycle.
  - rise_mode: RUN->SET_HOUR->SET_MIN->RUN.
  - clk_enable=1 only in RUN. clk_enable=0 in SET_HOUR and SET_MIN.
- Adjust:
  - In SET_HOUR, rise_up gives hour_inc and rise_down gives hour_dec.
  - In SET_MIN, the same buttons give min_inc and min_dec.
  - In RUN, up/down are ignored (no pulses, no repeat).
- Simultaneous events:
  - rise_mode in the same cycle as rise_up/rise_down: the mode transition wins and the adjust is dropped.
  - btn_up and btn_down both high: no pulses. The repeat state is cancelled and stays inhibited until both buttons are low.
- Mode change while a button is held: the repeat counter clears and no pulse is issued in the new state until a fresh rise.
- Timeout:
  - idle_ms counter clears on any button rise and whenever any button is high.
  - In a SET state, idle_ms reaching TIMEOUT_MS forces RUN on the next cycle.
  - Counter saturates and never wraps.
- Blink:
  - blink_ms counter toggles blink_phase every BLINK_MS, in SET states only. It is cleared to phase 0 on entry to any SET state.
  - blank = field mask when blink_phase=1 and btn_up=btn_down=0. Otherwise blank=0.
  - Field masks: SET_HOUR 4'b1100, SET_MIN 4'b0011. RUN always gives 4'b0000.
- Pulses never exceed one cycle. At most one of the four pulse outputs is high in any cycle.

Optional Feature:
- Macro: CLOCK_SET_AUTO_REPEAT_EN.
- Defined: a single adjust button held continuously for HOLD_MS ms in a SET state emits its pulse again, then once every REPEAT_MS ms while held. Release stops repeat immediately.
- Not defined: exactly one pulse per press. The hold/repeat counters and logic are absent.

Decomposition:
- Shared package clock_pkg holds:
  - mode_t enum (RUN, SET_HOUR, SET_MIN).
  - Field mask constants BLANK_HOUR=4'b1100 and BLANK_MIN=4'b0011.
  - MS_DIV function (CLK_HZ/1000).
- One natural sub-module, ms_tick_gen: parameterised prescaler producing tick_ms. It is reused by the other timing blocks.

Test Plan (sim with CLK_HZ=1000 so tick_ms fires every cycle; HOLD_MS=5, REPEAT_MS=2, BLINK_MS=3, TIMEOUT_MS=20):
- Reset, then mode presses:
  - After reset, clk_enable=1, mode_state=00, blank=0.
  - Press/release btn_mode -> mode_state=01, clk_enable=0.
  - Second press -> mode_state=10. Third press -> mode_state=00, clk_enable=1.
- Hour adjust: in SET_HOUR, 3 separate btn_up presses -> exactly 3 one-cycle hour_inc pulses, each 1 cycle after the rise. No min_* pulses.
- Auto-repeat (macro defined): in SET_MIN, hold btn_down for 12 cycles -> min_dec pulses at 1, 6, 8, 10, 12 cycles after the rise. With the macro undefined -> a single pulse.
- Conflicts:
  - In SET_HOUR, btn_up and btn_down rise in the same cycle -> zero pulses, also after holding 10 cycles.
  - btn_mode and btn_up rise together -> state advances, no hour_inc.
- Timeout: enter SET_HOUR and leave all buttons idle -> state returns to RUN 21 cycles after the last rise; clk_enable=1.
- Blink and async reset:
  - In SET_MIN with buttons idle, blank alternates 0000/0011 every 3 cycles.
  - Assert rst_n low mid-hold -> all outputs go to reset values immediately, without waiting for clk.
